// File: rtl/diskdrive_switch_if.sv
// Host-channel bundle between the drive switch, the FDC instances and the ctrl-module disk channel.
// The switch uses the slave modport; whatever drives the drive selects, FDC outputs and host channel uses master.
interface diskdrive_switch_if #(
  parameter int NR_DISK = 4
);
  localparam int IW = $clog2(NR_DISK);

  logic [NR_DISK-1:0]    sel_n;
  logic [32*NR_DISK-1:0] fdc_sr;
  logic [8*NR_DISK-1:0]  fdc_dout;
  logic [31:0]           disk_cr;
  logic                  disk_data_clkin;
  logic                  disk_data_clkout;
  logic [31:0]           disk_sr;
  logic [7:0]            disk_data_out;
  logic [32*NR_DISK-1:0] fdc_cr;
  logic [NR_DISK-1:0]    fdc_clkin;
  logic [NR_DISK-1:0]    fdc_clkout;
  logic [IW-1:0]         active;
  logic                  switched;

  modport slave (
    input  sel_n, fdc_sr, fdc_dout, disk_cr, disk_data_clkin, disk_data_clkout,
    output disk_sr, disk_data_out, fdc_cr, fdc_clkin, fdc_clkout, active, switched
  );

  modport master (
    output sel_n, fdc_sr, fdc_dout, disk_cr, disk_data_clkin, disk_data_clkout,
    input  disk_sr, disk_data_out, fdc_cr, fdc_clkin, fdc_clkout, active, switched
  );
endinterface

// File: rtl/diskdrive_switch.sv
// N-way switch connecting one of NR_DISK FDC instances to the single ctrl-module disk channel,
// with busy lock, pending-select queue, post-switch guard interval and optional round-robin service.
module diskdrive_switch #(
  parameter int NR_DISK = 4,
  parameter int MODE    = 0,
  parameter int REQ_BIT = 0,
  parameter int GUARD   = 16
) (
  input logic               clk24,
  input logic               rstn,
  diskdrive_switch_if.slave bus
);
  localparam int IW = $clog2(NR_DISK);
  localparam int SW = IW + 1;

  logic [IW-1:0]      active_q, active_d, target, rrCand;
  logic               switched_q, switched_d;
  logic [7:0]         guard_q, guard_d;
  logic [NR_DISK-1:0] pend_q, pend_d;
  logic [NR_DISK-1:0] prevSel_q;
  logic [NR_DISK-1:0] fall, req, activeMask;
  logic [SW-1:0]      rrSum;
  logic               lock, pendHit, rrHit, doSwitch;
  logic [31:0]        srArr   [NR_DISK];
  logic [7:0]         doutArr [NR_DISK];

  for (genvar g = 0; g < NR_DISK; g++) begin : g_slot
    assign req[g]                     = bus.fdc_sr[32*g+REQ_BIT];
    assign srArr[g]                   = bus.fdc_sr[32*g +: 32];
    assign doutArr[g]                 = bus.fdc_dout[8*g +: 8];
    assign bus.fdc_cr[32*g +: 32]     = (active_q == IW'(g)) ? bus.disk_cr : 32'd0;
    assign bus.fdc_clkin[g]           = bus.disk_data_clkin  & (active_q == IW'(g));
    assign bus.fdc_clkout[g]          = bus.disk_data_clkout & (active_q == IW'(g));
  end

  assign bus.disk_sr       = srArr[active_q];
  assign bus.disk_data_out = doutArr[active_q];
  assign bus.active        = active_q;
  assign bus.switched      = switched_q;

  assign fall       = prevSel_q & ~bus.sel_n;
  assign activeMask = {{(NR_DISK-1){1'b0}}, 1'b1} << active_q;
  assign lock       = req[active_q] | (guard_q != 8'd0);

  // Pending selects take priority (highest index wins); round-robin only fills idle slots.
  always_comb begin
    pendHit = 1'b0;
    rrHit   = 1'b0;
    target  = active_q;
    rrSum   = '0;
    rrCand  = '0;
    for (int i = 0; i < NR_DISK; i++) begin
      if (pend_q[i]) begin
        pendHit = 1'b1;
        target  = IW'(i);
      end
    end
    if (MODE == 1 && !pendHit) begin
      for (int k = 1; k < NR_DISK; k++) begin
        rrSum = {1'b0, active_q} + SW'(k);
        if (rrSum >= SW'(NR_DISK)) rrSum = rrSum - SW'(NR_DISK);
        rrCand = rrSum[IW-1:0];
        if (!rrHit && req[rrCand]) begin
          rrHit  = 1'b1;
          target = rrCand;
        end
      end
    end
    doSwitch   = !lock && (pendHit || rrHit);
    pend_d     = pend_q | (fall & ~activeMask);
    if (doSwitch) pend_d[target] = 1'b0;
    active_d   = doSwitch ? target : active_q;
    switched_d = doSwitch;
    if (doSwitch)              guard_d = 8'(GUARD);
    else if (guard_q != 8'd0)  guard_d = guard_q - 8'd1;
    else                       guard_d = 8'd0;
  end

  always_ff @(posedge clk24 or negedge rstn) begin
    if (!rstn) begin
      active_q   <= '0;
      switched_q <= 1'b0;
      guard_q    <= 8'd0;
      pend_q     <= '0;
      prevSel_q  <= '1;
    end else begin
      active_q   <= active_d;
      switched_q <= switched_d;
      guard_q    <= guard_d;
      pend_q     <= pend_d;
      prevSel_q  <= bus.sel_n;
    end
  end
endmodule

// File: doc/diskdrive_switch.md
# diskdrive_switch

Parametrised host-channel switch between `NR_DISK` WD1770-class FDC instances and the single ctrl-module disk channel (data, clock strobes, 32-bit status/control). It is the successor to the fixed two-drive switch. It adds N-way selection, a busy lock that defers a switch while the active drive needs the host, a pending-select queue, a post-switch guard interval, and an optional round-robin service mode. It sits between the Sam address decode and FDC instances on one side and the ctrl-module on the other.

## Interface
- `NR_DISK`, 4, number of drive channels (2..8); `IW = $clog2(NR_DISK)`.
- `MODE`, 0, 0 = CPU-select driven (legacy); 1 = CPU-select plus round-robin on drive requests.
- `REQ_BIT`, 0, bit of each FDC status word meaning "drive needs host service".
- `GUARD`, 16, minimum clk24 cycles between two switches (1..255).
- `clk24` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `sel_n` in NR_DISK: active-low CPU drive selects from decode (disk1_n, disk2_n, ...), synchronous to clk24.
- `fdc_sr` in 32*NR_DISK: status word of FDC i at [32i+31:32i].
- `fdc_dout` in 8*NR_DISK: disk data out of FDC i at [8i+7:8i].
- `disk_cr` in 32: host control word.
- `disk_data_clkin`, `disk_data_clkout` in 1: host data strobes.
- `disk_sr` out 32: `fdc_sr` of active drive.
- `disk_data_out` out 8: `fdc_dout` of active drive.
- `fdc_cr` out 32*NR_DISK: `disk_cr` on active slot, 0 elsewhere.
- `fdc_clkin`, `fdc_clkout` out NR_DISK: host strobes gated to active slot only.
- `active` out IW: registered active drive index.
- `switched` out 1: one-cycle pulse the cycle `active` changes.

## Operation
- Edge detect: `prev_sel` register (reset all ones); `fall[i] = prev_sel[i] & ~sel_n[i]`.
- Pending: `pend[i]` set on `fall[i]`; cleared when drive i becomes active, or when `fall` is seen for i while i is already active (no switch, no pulse).
- Lock: `lock = fdc_sr[32*active+REQ_BIT] | (guard_cnt != 0)`.
- Switch decision, evaluated every cycle when `!lock`:
  - If any `pend` bit is set, target = highest pending index (matches the legacy priority, where the later drive wins).
  - Otherwise, if `MODE==1` and some inactive drive has its REQ_BIT set, target = first such index scanning active+1, active+2, ... with wrap modulo NR_DISK.
  - Otherwise, no switch.
- On switch: `active` <= target, `pend[target]` cleared, `switched` = 1 for that cycle, `guard_cnt` <= GUARD.
- `guard_cnt` decrements by 1 per cycle to 0 and saturates at 0.
- Fall edges arriving while locked only set `pend`. None are lost, and several may accumulate.
- Output muxing and strobe gating are combinational from the registered `active`. Inactive slots never see a strobe or a non-zero `cr`.
- Out-of-range index (not a power of two, index >= NR_DISK) is never produced. The scan skips such indices.

## Timing
- Reset values:
  - `active`=0, `switched`=0, `guard_cnt`=0, `pend`=0, `prev_sel`=all ones.
  - `disk_sr`/`disk_data_out` follow drive 0; `fdc_cr` is 0 except slot 0, which carries `disk_cr`.
- Latency: `sel_n[i]` falls at cycle t, unlocked → `active`=i and `switched`=1 at t+2.
  - t+1: `prev_sel` and `pend` update.
  - t+2: switch.
- Locked by REQ_BIT: switch occurs 1 cycle after REQ_BIT of the active drive is seen low, provided guard is 0.
- Guard: after a switch at cycle s, the next switch is no earlier than s+GUARD+1.
- Simultaneous fall edges: all are set pending. The highest index switches first, and the others are served after the guard expires.
- Fall on the current target in the same cycle as the switch: the pending bit stays clear.
- Reset mid-operation: all state returns to reset values asynchronously. Any pending selects are discarded.

## Test plan
- NR_DISK=4, MODE=0, GUARD=16: reset, pulse `sel_n[2]` low → `active`=2 and `switched` pulse exactly 2 cycles later; `fdc_clkin` strobes appear only on bit 2.
- Drive 2 active with `fdc_sr[64]`=1, pulse `sel_n[1]` → no switch while held; drop REQ → `active`=1 one cycle later.
- Pulse `sel_n[0]` and `sel_n[3]` in the same cycle → `active`=3, then `active`=0 exactly GUARD+1 cycles later.
- MODE=1, no CPU selects, REQ set on drives 1 and 3, active=2 → next `active`=3, then 1 after guard and release.
- Pulse `sel_n` on the already-active drive → no `switched` pulse, `pend`=0.
- Assert `rstn`=0 with `pend`=4'b1010 and guard running → all outputs at reset values, and no switch after release.
